// File: rtl/debug_cmd_parser.sv
// Purpose : parses W/R debug frames from the UART RX byte stream into register strobes.
// Latency : reg_wr_en / reg_rd_en assert the cycle after the 0x0A terminator is sampled.
// Backpressure: none; bytes arriving while a command executes are dropped and counted as errors.
//
// Ports:
//   clk_in, reset          - clock, async active-low reset
//   cmd_byte, cmd_valid    - received byte with one-cycle valid pulse
//   reg_wr_en, reg_rd_en   - one-cycle register write / read strobes
//   reg_addr, reg_wr_data  - target address and write data (held after a frame)
//   reg_rd_data, reg_rd_ack- read return data and its valid
//   status_word            - {reg_addr, last read byte} for the debugger TX dump
//   err_count, frame_count - saturating error count, wrapping completed-frame count
//   parser_state, parser_busy - FSM visibility
module debug_cmd_parser #(
  parameter int                             TIMEOUT_TICKS_WIDTH = 24,
  parameter logic [TIMEOUT_TICKS_WIDTH-1:0] TIMEOUT_TICKS       = 24'd2200000,
  parameter int                             ACK_TIMEOUT_WIDTH   = 8,
  parameter logic [ACK_TIMEOUT_WIDTH-1:0]   ACK_TIMEOUT_TICKS   = 8'd200
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [7:0]  cmd_byte,
  input  logic        cmd_valid,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_wr_data,
  input  logic [7:0]  reg_rd_data,
  input  logic        reg_rd_ack,
  output logic [15:0] status_word,
  output logic [7:0]  err_count,
  output logic [7:0]  frame_count,
  output logic [3:0]  parser_state,
  output logic        parser_busy
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GET_ADDR = 4'd1,
    GET_DATA = 4'd2,
    GET_TERM = 4'd3,
    EXEC_WR  = 4'd4,
    WAIT_ACK = 4'd5
  } state_e;

  // Last counter value before expiry; counters start at 0 on entry.
  localparam logic [TIMEOUT_TICKS_WIDTH-1:0] TO_LAST  = TIMEOUT_TICKS - TIMEOUT_TICKS_WIDTH'(1);
  localparam logic [ACK_TIMEOUT_WIDTH-1:0]   ACK_LAST = ACK_TIMEOUT_TICKS - ACK_TIMEOUT_WIDTH'(1);

  state_e                         state_q, state_d;
  logic                           op_wr_q, op_wr_d;
  logic [7:0]                     addr_q, addr_d;
  logic [7:0]                     wdata_q, wdata_d;
  logic [7:0]                     rd_byte_q, rd_byte_d;
  logic [TIMEOUT_TICKS_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic [ACK_TIMEOUT_WIDTH-1:0]   ack_cnt_q, ack_cnt_d;
  logic                           wr_en_q, wr_en_d;
  logic                           rd_en_q, rd_en_d;
  logic                           busy_q, busy_d;
  logic [7:0]                     err_q, err_d;
  logic [7:0]                     frame_q, frame_d;
  logic                           err_inc;
  logic                           frame_inc;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_wr_q   <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      rd_byte_q <= 8'h00;
      to_cnt_q  <= '0;
      ack_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 8'h00;
      frame_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_byte_q <= rd_byte_d;
      to_cnt_q  <= to_cnt_d;
      ack_cnt_q <= ack_cnt_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      frame_q   <= frame_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_byte_d = rd_byte_q;
    to_cnt_d  = to_cnt_q;
    ack_cnt_d = ack_cnt_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    err_inc   = 1'b0;
    frame_inc = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_byte)
            8'h57, 8'h77: begin
              op_wr_d  = 1'b1;
              to_cnt_d = '0;
              state_d  = GET_ADDR;
            end
            8'h52, 8'h72: begin
              op_wr_d  = 1'b0;
              to_cnt_d = '0;
              state_d  = GET_ADDR;
            end
            8'h0A, 8'h0D, 8'h20: ;  // line noise between frames
            default: err_inc = 1'b1;
          endcase
        end
      end

      // Inside a frame a byte on the expiry edge takes priority over the timeout.
      GET_ADDR, GET_DATA, GET_TERM: begin
        if (cmd_valid) begin
          to_cnt_d = '0;
          if (state_q == GET_ADDR) begin
            addr_d  = cmd_byte;
            state_d = op_wr_q ? GET_DATA : GET_TERM;
          end else if (state_q == GET_DATA) begin
            wdata_d = cmd_byte;
            state_d = GET_TERM;
          end else if (cmd_byte == 8'h0A) begin
            if (op_wr_q) begin
              wr_en_d = 1'b1;
              state_d = EXEC_WR;
            end else begin
              rd_en_d   = 1'b1;
              ack_cnt_d = '0;
              state_d   = WAIT_ACK;
            end
          end else begin
            err_inc = 1'b1;
            state_d = IDLE;
          end
        end else if (to_cnt_q == TO_LAST) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TIMEOUT_TICKS_WIDTH'(1);
        end
      end

      EXEC_WR: begin
        frame_inc = 1'b1;
        state_d   = IDLE;
        if (cmd_valid) err_inc = 1'b1;
      end

      WAIT_ACK: begin
        if (cmd_valid) err_inc = 1'b1;
        if (reg_rd_ack) begin
          rd_byte_d = reg_rd_data;
          frame_inc = 1'b1;
          state_d   = IDLE;
        end else if (ack_cnt_q == ACK_LAST) begin
          rd_byte_d = 8'hEE;
          err_inc   = 1'b1;
          state_d   = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_TIMEOUT_WIDTH'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    // Coinciding error causes collapse into a single increment via err_inc.
    err_d   = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    frame_d = frame_inc ? frame_q + 8'd1 : frame_q;
  end

  assign reg_wr_en    = wr_en_q;
  assign reg_rd_en    = rd_en_q;
  assign reg_addr     = addr_q;
  assign reg_wr_data  = wdata_q;
  assign status_word  = {addr_q, rd_byte_q};
  assign err_count    = err_q;
  assign frame_count  = frame_q;
  assign parser_state = state_q;
  assign parser_busy  = busy_q;

endmodule

// File: tb/tb_debug_cmd_parser.sv
// Purpose : directed self-checking bench for debug_cmd_parser (inter-byte timeout shortened to 50).
// Latency : bytes are driven on the falling edge and sampled on the next rising edge.
// Backpressure: none modelled; the bench paces bytes itself.
module tb_debug_cmd_parser;

  logic        clk_in;
  logic        reset;
  logic [7:0]  cmd_byte;
  logic        cmd_valid;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_wr_data;
  logic [7:0]  reg_rd_data;
  logic        reg_rd_ack;
  logic [15:0] status_word;
  logic [7:0]  err_count;
  logic [7:0]  frame_count;
  logic [3:0]  parser_state;
  logic        parser_busy;

  int errors = 0;
  int checks = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int wr_base;
  int rd_base;

  debug_cmd_parser #(
    .TIMEOUT_TICKS_WIDTH(24),
    .TIMEOUT_TICKS      (24'd50),
    .ACK_TIMEOUT_WIDTH  (8),
    .ACK_TIMEOUT_TICKS  (8'd200)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .cmd_byte    (cmd_byte),
    .cmd_valid   (cmd_valid),
    .reg_wr_en   (reg_wr_en),
    .reg_rd_en   (reg_rd_en),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .reg_rd_data (reg_rd_data),
    .reg_rd_ack  (reg_rd_ack),
    .status_word (status_word),
    .err_count   (err_count),
    .frame_count (frame_count),
    .parser_state(parser_state),
    .parser_busy (parser_busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (reg_wr_en) wr_pulses++;
    if (reg_rd_en) rd_pulses++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Called at a falling edge; the byte is consumed on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    cmd_byte  = b;
    cmd_valid = 1'b1;
    @(negedge clk_in);
    cmd_valid = 1'b0;
    cmd_byte  = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
    wr_base = wr_pulses;
    rd_base = rd_pulses;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_byte    = 8'h00;
    reg_rd_ack  = 1'b0;
    reg_rd_data = 8'h00;
    idle(3);
    checks++;
    if ({reg_wr_en, reg_rd_en, parser_busy, parser_state} !== 7'h0) begin
      errors++; $display("FAIL reset_ctrl: got %h want 0", {reg_wr_en, reg_rd_en, parser_busy, parser_state});
    end
    checks++;
    if ({status_word, err_count, frame_count, reg_wr_data} !== 40'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {status_word, err_count, frame_count, reg_wr_data});
    end
    do_reset();
  endtask

  task automatic test_write();
    do_reset();
    send_byte(8'h57); idle(2);
    send_byte(8'h12); idle(2);
    send_byte(8'hA5); idle(2);
    send_byte(8'h0A);
    checks++;
    if ({reg_wr_en, parser_busy, parser_state} !== 6'b1_1_0100) begin
      errors++; $display("FAIL wr_strobe: got %b want 110100", {reg_wr_en, parser_busy, parser_state});
    end
    idle(1);
    checks++;
    if ({reg_wr_en, parser_busy, parser_state} !== 6'b0) begin
      errors++; $display("FAIL wr_after: got %b want 000000", {reg_wr_en, parser_busy, parser_state});
    end
    checks++;
    if ({reg_addr, reg_wr_data, frame_count, err_count} !== 32'h12A5_0100) begin
      errors++; $display("FAIL wr_regs: got %h want 12a50100", {reg_addr, reg_wr_data, frame_count, err_count});
    end
    checks++;
    if (wr_pulses - wr_base !== 1) begin
      errors++; $display("FAIL wr_pulses: got %0d want 1", wr_pulses - wr_base);
    end
  endtask

  task automatic test_read();
    do_reset();
    send_byte(8'h72);
    send_byte(8'h34);
    send_byte(8'h0A);
    checks++;
    if ({reg_rd_en, parser_state} !== 5'b1_0101) begin
      errors++; $display("FAIL rd_strobe: got %b want 10101", {reg_rd_en, parser_state});
    end
    idle(1);
    checks++;
    if (reg_rd_en !== 1'b0) begin
      errors++; $display("FAIL rd_strobe_end: got %b want 0", reg_rd_en);
    end
    idle(1);
    reg_rd_ack  = 1'b1;
    reg_rd_data = 8'h5C;
    idle(1);
    reg_rd_ack  = 1'b0;
    reg_rd_data = 8'h00;
    checks++;
    if ({status_word, frame_count, err_count, parser_busy} !== 33'h0_345C_0100 << 1) begin
      errors++; $display("FAIL rd_result: got %h want %h", {status_word, frame_count, err_count, parser_busy}, 33'h0_345C_0100 << 1);
    end
    checks++;
    if (rd_pulses - rd_base !== 1) begin
      errors++; $display("FAIL rd_pulses: got %0d want 1", rd_pulses - rd_base);
    end
  endtask

  task automatic test_ack_timeout();
    do_reset();
    send_byte(8'h52);
    send_byte(8'h40);
    send_byte(8'h0A);
    idle(199);
    checks++;
    if ({parser_busy, parser_state} !== 5'b1_0101) begin
      errors++; $display("FAIL ack_wait_199: got %b want 10101", {parser_busy, parser_state});
    end
    idle(1);
    checks++;
    if ({status_word, err_count, frame_count, parser_busy} !== {16'h40EE, 8'd1, 8'd0, 1'b0}) begin
      errors++; $display("FAIL ack_timeout: got %h want %h", {status_word, err_count, frame_count, parser_busy}, {16'h40EE, 8'd1, 8'd0, 1'b0});
    end
  endtask

  task automatic test_byte_timeout();
    do_reset();
    send_byte(8'h57);
    send_byte(8'h01);
    idle(49);
    checks++;
    if ({parser_state, err_count} !== {4'd2, 8'd0}) begin
      errors++; $display("FAIL to_before: got %h want 200", {parser_state, err_count});
    end
    idle(1);
    checks++;
    if ({parser_state, err_count} !== {4'd0, 8'd1}) begin
      errors++; $display("FAIL to_expire: got %h want 001", {parser_state, err_count});
    end
    checks++;
    if (wr_pulses - wr_base !== 0) begin
      errors++; $display("FAIL to_no_strobe: got %0d want 0", wr_pulses - wr_base);
    end
    // Byte lands on the expiry edge: it must be accepted with no error.
    do_reset();
    send_byte(8'h57);
    idle(49);
    send_byte(8'h01);
    checks++;
    if ({parser_state, err_count, reg_addr} !== {4'd2, 8'd0, 8'h01}) begin
      errors++; $display("FAIL to_race: got %h want 20001", {parser_state, err_count, reg_addr});
    end
  endtask

  task automatic test_bad_term();
    do_reset();
    send_byte(8'h57);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h41);
    checks++;
    if ({parser_state, err_count, reg_addr, reg_wr_data} !== {4'd0, 8'd1, 8'h01, 8'h02}) begin
      errors++; $display("FAIL bad_term: got %h want 0010102", {parser_state, err_count, reg_addr, reg_wr_data});
    end
    send_byte(8'h58);
    checks++;
    if (err_count !== 8'd2) begin
      errors++; $display("FAIL bad_idle_byte: got %0d want 2", err_count);
    end
    send_byte(8'h0A);
    send_byte(8'h0D);
    send_byte(8'h20);
    idle(1);
    checks++;
    if ({parser_state, err_count} !== {4'd0, 8'd2}) begin
      errors++; $display("FAIL whitespace: got %h want 002", {parser_state, err_count});
    end
    checks++;
    if (wr_pulses - wr_base !== 0) begin
      errors++; $display("FAIL bad_no_strobe: got %0d want 0", wr_pulses - wr_base);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_byte(8'h57); send_byte(8'h21); send_byte(8'h22); send_byte(8'h0A);
    idle(1);
    send_byte(8'h58);
    send_byte(8'h57);
    send_byte(8'h12);
    checks++;
    if ({parser_state, frame_count, err_count} !== {4'd2, 8'd1, 8'd1}) begin
      errors++; $display("FAIL pre_reset: got %h want 20101", {parser_state, frame_count, err_count});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({reg_wr_en, reg_rd_en, parser_busy, parser_state, status_word, err_count, frame_count, reg_wr_data} !== 47'h0) begin
      errors++; $display("FAIL async_reset: got %h want 0", {reg_wr_en, reg_rd_en, parser_busy, parser_state, status_word, err_count, frame_count, reg_wr_data});
    end
    idle(2);
    reset = 1'b1;
    idle(1);
    wr_base = wr_pulses;
    send_byte(8'h77); send_byte(8'h33); send_byte(8'h44); send_byte(8'h0A);
    idle(1);
    checks++;
    if ({reg_addr, reg_wr_data, frame_count, err_count} !== 32'h3344_0100) begin
      errors++; $display("FAIL post_reset_wr: got %h want 33440100", {reg_addr, reg_wr_data, frame_count, err_count});
    end
    checks++;
    if (wr_pulses - wr_base !== 1) begin
      errors++; $display("FAIL post_reset_pulse: got %0d want 1", wr_pulses - wr_base);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 254; i++) send_byte(8'h58);
    checks++;
    if (err_count !== 8'd254) begin
      errors++; $display("FAIL err_254: got %0d want 254", err_count);
    end
    for (int i = 0; i < 46; i++) send_byte(8'h58);
    checks++;
    if (err_count !== 8'd255) begin
      errors++; $display("FAIL err_sat: got %0d want 255", err_count);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ack_timeout();
    test_byte_timeout();
    test_bad_term();
    test_reset_midframe();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_cmd_parser.md
Name: debug_cmd_parser

Overview:
- Downstream consumer of the debug UART receive path.
- Takes the byte stream (byte plus one-cycle valid pulse) received on the debug RX line and parses fixed-format write/read frames.
- Issues single-cycle register write/read strobes toward design control registers.
- Exposes a 16-bit status word sized to feed the debugger's periodic TX dump (its data input), so read-back results appear on the debug serial output.

Parameters:
TIMEOUT_TICKS_WIDTH, 24, width of inter-byte timeout counter
TIMEOUT_TICKS, 24'd2200000, idle cycles allowed between bytes inside a frame (~100 ms at 22 MHz)
ACK_TIMEOUT_WIDTH, 8, width of read-ack timeout counter
ACK_TIMEOUT_TICKS, 8'd200, cycles allowed for reg_rd_ack after a read strobe

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-low reset
cmd_byte  input  8  received byte, valid only when cmd_valid=1
cmd_valid  input  1  one-cycle pulse per received byte
reg_wr_en  output  1  one-cycle register write strobe
reg_rd_en  output  1  one-cycle register read strobe
reg_addr  output  8  target register address, held after a frame
reg_wr_data  output  8  write data, held after a frame
reg_rd_data  input  8  read data, sampled when reg_rd_ack=1
reg_rd_ack  input  1  read data valid
status_word  output  16  {reg_addr, last read byte}; feeds debugger data input
err_count  output  8  saturating protocol error count
frame_count  output  8  completed frame count, wraps 255->0
parser_state  output  4  current FSM state (debug visibility)
parser_busy  output  1  1 when parser_state != IDLE

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0, including status_word, err_count, frame_count, reg_addr and reg_wr_data. An in-flight frame is discarded with no strobe.
- Frame formats (bytes):
  - Write: opcode 'W'(0x57) or 'w'(0x77), addr, data, 0x0A.
  - Read: opcode 'R'(0x52) or 'r'(0x72), addr, 0x0A.
- All outputs are registered. A byte is consumed on the clk_in edge where cmd_valid=1.
- States (parser_state encoding):
  - IDLE = 0:
    - Write opcode -> GET_ADDR, op latched as write.
    - Read opcode -> GET_ADDR, op latched as read.
    - 0x0A, 0x0D, 0x20 -> ignored silently.
    - Any other byte -> err_count+1, stay IDLE.
  - GET_ADDR = 1: byte -> reg_addr. Next state GET_DATA for write, GET_TERM for read.
  - GET_DATA = 2: byte -> reg_wr_data; next GET_TERM.
  - GET_TERM = 3:
    - 0x0A, write op -> EXEC_WR.
    - 0x0A, read op -> WAIT_ACK, with reg_rd_en=1 for the following cycle only.
    - Any other byte -> err_count+1, IDLE, no strobe. reg_addr/reg_wr_data keep the partial values.
  - EXEC_WR = 4: reg_wr_en=1 for exactly this one cycle; frame_count+1; next IDLE.
  - WAIT_ACK = 5:
    - reg_rd_ack sampled every cycle of WAIT_ACK, including the reg_rd_en cycle.
    - On ack: status_word[7:0] <= reg_rd_data, frame_count+1, IDLE.
    - No ack within ACK_TIMEOUT_TICKS cycles: status_word[7:0] <= 8'hEE, err_count+1, IDLE.
- status_word[15:8] always mirrors reg_addr.
- Latency:
  - Write: terminator sampled at edge N; reg_wr_en high during cycle N..N+1; parser_busy low from edge N+1.
  - Read: terminator sampled at edge N; reg_rd_en high during cycle N..N+1.
- Inter-byte timeout:
  - Counter runs in GET_ADDR/GET_DATA/GET_TERM and clears on each accepted byte and on entering those states.
  - Reaching TIMEOUT_TICKS -> err_count+1, IDLE.
  - A cmd_valid on the same edge as expiry wins: the byte is processed and no error is counted.
- Bytes arriving in EXEC_WR or WAIT_ACK are dropped with err_count+1. A WAIT_ACK exit on the same edge still completes normally.
- err_count saturates at 255. frame_count wraps.
- If two error causes coincide on one edge, err_count increments once.

Test Plan:
- Bytes 'W',0x12,0xA5,0x0A at 3-cycle spacing -> one reg_wr_en pulse one cycle after the 0x0A edge; reg_addr=0x12; reg_wr_data=0xA5; frame_count=1; err_count=0.
- 'r',0x34,0x0A; reg_rd_ack=1 with reg_rd_data=0x5C 3 cycles after reg_rd_en -> single reg_rd_en pulse; status_word=0x345C; frame_count=1.
- 'R',0x40,0x0A with ack never asserted -> after 200 cycles status_word=0x40EE, err_count=1, parser_busy=0.
- 'W',0x01 then silence for TIMEOUT_TICKS (reduced to 50 in bench) -> err_count=1, IDLE, no reg_wr_en. Repeat with a byte arriving exactly at expiry -> no error, state GET_DATA.
- 'W',0x01,0x02,0x41 (bad terminator) then 'X' -> no strobe, err_count=2; also 0x0A/0x0D/0x20 in IDLE -> err_count unchanged.
- Reset pulled low during GET_DATA -> all outputs 0 immediately (async); after release, a full write frame completes normally; 300 garbage bytes -> err_count holds at 255.
